// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: opcode encoding, status flag bit positions,
// FSM state type and the parity helper.
package alu_pipe_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADC   = 5'd1,
        OP_SUB   = 5'd2,
        OP_SBB   = 5'd3,
        OP_INC   = 5'd4,
        OP_DEC   = 5'd5,
        OP_AND   = 5'd6,
        OP_OR    = 5'd7,
        OP_XOR   = 5'd8,
        OP_NOT   = 5'd9,
        OP_SHL1  = 5'd10,
        OP_SHR1  = 5'd11,
        OP_SAR1  = 5'd12,
        OP_ROL1  = 5'd13,
        OP_ROR1  = 5'd14,
        OP_PASSA = 5'd15,
        OP_CMP   = 5'd16,
        OP_MUL   = 5'd17
    } opcode_e;

    localparam int FLAG_CF = 5;
    localparam int FLAG_ZF = 4;
    localparam int FLAG_NF = 3;
    localparam int FLAG_VF = 2;
    localparam int FLAG_PF = 1;
    localparam int FLAG_AF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic even_parity8(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle.
// done is asserted combinationally during the last iteration with the full product.
module alu_pipe_mul
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_next_acc;

    assign w_next_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_done     = r_busy && (r_cnt == LAST);
    assign o_product  = w_next_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_busy) begin
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end else begin
                r_acc    <= w_next_acc;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake on both sides and a registered result.
// Define ALU_PIPE_MUL_EN to implement opcode 17 (MUL) with the iterative multiplier.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       F,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [5:0]       Status,
    output logic             err
);

    localparam int W1 = WIDTH + 1;

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_result;
    logic [5:0]       r_status;
    logic             r_err;

    logic             w_accept;
    logic             w_start;
    logic [WIDTH-1:0] w_opb;
    logic             w_cin;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic             w_af_arith;
    logic             w_vf_arith;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_fres;
    logic             w_cf;
    logic             w_vf;
    logic             w_af;
    logic             w_err;
    logic             w_is_mul;
    logic [5:0]       w_status;

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
    assign out_valid = (r_state == ST_HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && w_is_mul;
    assign Result    = r_result;
    assign Status    = r_status;
    assign err       = r_err;

    // One shared WIDTH+1 adder/subtractor serves every arithmetic opcode.
    always_comb begin
        w_opb = B;
        w_cin = 1'b0;
        w_sub = 1'b0;
        case (F)
            OP_ADC:         w_cin = Cin;
            OP_SUB, OP_CMP: w_sub = 1'b1;
            OP_SBB: begin
                w_sub = 1'b1;
                w_cin = Cin;
            end
            OP_INC:         w_opb = WIDTH'(1);
            OP_DEC: begin
                w_opb = WIDTH'(1);
                w_sub = 1'b1;
            end
            default: ;
        endcase
        if (w_sub)
            w_sum = {1'b0, A} - {1'b0, w_opb} - W1'(w_cin);
        else
            w_sum = {1'b0, A} + {1'b0, w_opb} + W1'(w_cin);
        // Carry/borrow into bit 4 equals the carry/borrow out of bit 3.
        w_af_arith = A[4] ^ w_opb[4] ^ w_sum[4];
        if (w_sub)
            w_vf_arith = (A[WIDTH-1] != w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
        else
            w_vf_arith = (A[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
    end

    always_comb begin
        w_res    = '0;
        w_cf     = 1'b0;
        w_vf     = 1'b0;
        w_af     = 1'b0;
        w_err    = 1'b0;
        w_is_mul = 1'b0;
        case (F)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_vf  = w_vf_arith;
                w_af  = w_af_arith;
            end
            OP_CMP: begin
                w_res = A;
                w_cf  = w_sum[WIDTH];
                w_vf  = w_vf_arith;
                w_af  = w_af_arith;
            end
            OP_AND:   w_res = A & B;
            OP_OR:    w_res = A | B;
            OP_XOR:   w_res = A ^ B;
            OP_NOT:   w_res = ~A;
            OP_PASSA: w_res = A;
            OP_SHL1: begin
                w_res = {A[WIDTH-2:0], 1'b0};
                w_cf  = A[WIDTH-1];
            end
            OP_SHR1: begin
                w_res = {1'b0, A[WIDTH-1:1]};
                w_cf  = A[0];
            end
            OP_SAR1: begin
                w_res = {A[WIDTH-1], A[WIDTH-1:1]};
                w_cf  = A[0];
            end
            OP_ROL1: begin
                w_res = {A[WIDTH-2:0], A[WIDTH-1]};
                w_cf  = A[WIDTH-1];
            end
            OP_ROR1: begin
                w_res = {A[0], A[WIDTH-1:1]};
                w_cf  = A[0];
            end
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:   w_is_mul = 1'b1;
`endif
            default:  w_err = 1'b1;
        endcase
        // CMP reports the flags of the difference while returning A.
        w_fres   = (F == OP_CMP) ? w_sum[WIDTH-1:0] : w_res;
        w_status = '0;
        if (!w_err) begin
            w_status[FLAG_CF] = w_cf;
            w_status[FLAG_ZF] = (w_fres == '0);
            w_status[FLAG_NF] = w_fres[WIDTH-1];
            w_status[FLAG_VF] = w_vf;
            w_status[FLAG_PF] = even_parity8(w_fres[7:0]);
            w_status[FLAG_AF] = w_af;
        end
    end

`ifdef ALU_PIPE_MUL_EN
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;
    logic [5:0]         w_mul_status;
    logic               w_mul_hi_nz;

    alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_a       (A),
        .i_b       (B),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    always_comb begin
        w_mul_hi_nz           = |w_mul_product[2*WIDTH-1:WIDTH];
        w_mul_status          = '0;
        w_mul_status[FLAG_CF] = w_mul_hi_nz;
        w_mul_status[FLAG_VF] = w_mul_hi_nz;
        w_mul_status[FLAG_ZF] = (w_mul_product[WIDTH-1:0] == '0);
        w_mul_status[FLAG_NF] = w_mul_product[WIDTH-1];
        w_mul_status[FLAG_PF] = even_parity8(w_mul_product[7:0]);
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_accept)
                    w_next = w_start ? ST_BUSY : ST_HOLD;
                else if (r_state == ST_HOLD && out_ready)
                    w_next = ST_IDLE;
            end
            ST_BUSY: begin
`ifdef ALU_PIPE_MUL_EN
                if (w_mul_done)
                    w_next = ST_HOLD;
`else
                w_next = ST_IDLE;
`endif
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_status <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_is_mul) begin
                r_result <= w_res;
                r_status <= w_status;
                r_err    <= w_err;
            end
`ifdef ALU_PIPE_MUL_EN
            else if (r_state == ST_BUSY && w_mul_done) begin
                r_result <= w_mul_product[WIDTH-1:0];
                r_status <= w_mul_status;
                r_err    <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): vector table plus handshake,
// latency, backpressure and reset-abort sequences, with a result scoreboard.
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [4:0]   F = '0;
  logic         Cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Result;
  logic [5:0]   Status;
  logic         err;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .F         (F),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Status    (Status),
    .err       (err)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_tests = 0;
  int n_fail = 0;
  logic [22:0] exp_q[$];
  logic [22:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got Result=0x%0h with empty expected queue", Result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 32'(Result), 32'(mon_e[22:7]));
        check("status", 32'(Status), 32'(mon_e[6:1]));
        check("err", 32'(err), 32'(mon_e[0]));
      end
    end
  end

  // driver tasks
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] f,
                          input logic cin, input logic [22:0] exp);
    int n;
    A = a;
    B = b;
    F = f;
    Cin = cin;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", n);
    end else begin
      @(posedge clk);
      exp_q.push_back(exp);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
  endtask

  // vector table
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   f;
    logic         cin;
    logic [W-1:0] res;
    logic [5:0]   st;
    logic         err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    int n;
    int c0;
    int cnt;
    logic [22:0] mul_exp;
    logic [22:0] mul_ovf_exp;
    logic [22:0] mul_abort_exp;
    int mul_lat;

    vecs[0]  = '{16'h7FFF, 16'h0001, 5'd0,  1'b0, 16'h8000, 6'h0F, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0000, 5'd1,  1'b1, 16'h0000, 6'h33, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0005, 5'd2,  1'b0, 16'h0000, 6'h12, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0005, 5'd16, 1'b0, 16'h0005, 6'h12, 1'b0};
    vecs[4]  = '{16'h0000, 16'h0001, 5'd3,  1'b1, 16'hFFFE, 6'h29, 1'b0};
    vecs[5]  = '{16'h00FF, 16'h1234, 5'd4,  1'b0, 16'h0100, 6'h03, 1'b0};
    vecs[6]  = '{16'h8000, 16'h1234, 5'd5,  1'b0, 16'h7FFF, 6'h07, 1'b0};
    vecs[7]  = '{16'hF0F0, 16'h0FF0, 5'd6,  1'b0, 16'h00F0, 6'h02, 1'b0};
    vecs[8]  = '{16'h8001, 16'h0002, 5'd7,  1'b0, 16'h8003, 6'h0A, 1'b0};
    vecs[9]  = '{16'h1234, 16'h1234, 5'd8,  1'b0, 16'h0000, 6'h12, 1'b0};
    vecs[10] = '{16'h00FF, 16'h0000, 5'd9,  1'b0, 16'hFF00, 6'h0A, 1'b0};
    vecs[11] = '{16'h8001, 16'h0000, 5'd10, 1'b0, 16'h0002, 6'h20, 1'b0};
    vecs[12] = '{16'h8001, 16'h0000, 5'd11, 1'b0, 16'h4000, 6'h22, 1'b0};
    vecs[13] = '{16'h8002, 16'h0000, 5'd12, 1'b0, 16'hC001, 6'h08, 1'b0};
    vecs[14] = '{16'h8001, 16'h0000, 5'd13, 1'b0, 16'h0003, 6'h22, 1'b0};
    vecs[15] = '{16'h0001, 16'h0000, 5'd14, 1'b0, 16'h8000, 6'h2A, 1'b0};
    vecs[16] = '{16'h0000, 16'hFFFF, 5'd15, 1'b1, 16'h0000, 6'h12, 1'b0};
    vecs[17] = '{16'h1234, 16'h5678, 5'h1F, 1'b0, 16'h0000, 6'h00, 1'b1};
    vecs[18] = '{16'hABCD, 16'h0001, 5'h12, 1'b1, 16'h0000, 6'h00, 1'b1};

`ifdef ALU_PIPE_MUL_EN
    mul_exp       = {16'h03A8, 6'h00, 1'b0};
    mul_ovf_exp   = {16'h0000, 6'h36, 1'b0};
    mul_abort_exp = {16'h000F, 6'h02, 1'b0};
    mul_lat       = W + 1;
`else
    mul_exp       = {16'h0000, 6'h00, 1'b1};
    mul_ovf_exp   = {16'h0000, 6'h00, 1'b1};
    mul_abort_exp = {16'h0000, 6'h00, 1'b1};
    mul_lat       = 1;
`endif

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(Result), 32'h0000);
    check("rst_status", 32'(Status), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // table, back-to-back with out_ready=1
    c0 = cyc;
    for (int i = 0; i < NV; i++) begin
      drive_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].cin, {vecs[i].res, vecs[i].st, vecs[i].err});
    end
    check("throughput_cycles", 32'(cyc - c0), 32'(NV));

    // single-cycle latency
    drive_op(16'h0001, 16'h0002, 5'd0, 1'b0, {16'h0003, 6'h02, 1'b0});
    wait_valid(n);
    check("lat_single", 32'(n), 32'd1);
    @(posedge clk);
    #1;

    // backpressure
    out_ready = 1'b0;
    drive_op(16'h00FF, 16'h0F0F, 5'd8, 1'b0, {16'h0FF0, 6'h02, 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result_held", 32'(Result), 32'h0FF0);
      check("bp_status_held", 32'(Status), 32'h02);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    A = 16'h0001;
    B = 16'h0001;
    F = 5'd0;
    Cin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back({16'h0002, 6'h00, 1'b0});
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // multiply
    drive_op(16'h0012, 16'h0034, 5'd17, 1'b0, mul_exp);
    wait_valid(n);
    check("lat_mul", 32'(n), 32'(mul_lat));
    @(posedge clk);
    #1;
    drive_op(16'h0100, 16'h0100, 5'd17, 1'b0, mul_ovf_exp);
    wait_valid(n);
    check("lat_mul_ovf", 32'(n), 32'(mul_lat));
    @(posedge clk);
    #1;

    // reset in the middle of a multiply
    drive_op(16'h0003, 16'h0005, 5'd17, 1'b0, mul_abort_exp);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", 32'(Result), 32'h0000);
    check("abort_status", 32'(Status), 32'd0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("abort_no_output", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;

    // recovery after abort
    drive_op(16'hFFFF, 16'h5555, 5'd6, 1'b0, {16'h5555, 6'h02, 1'b0});
    wait_valid(n);
    check("lat_recover", 32'(n), 32'd1);
    @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
